// File: rtl/button_press_classifier.sv
// Classifies a debounced switch into short, long, double and auto-repeat events.
// One shared saturating counter times press length, release gap and repeat period.
module button_press_classifier #(
    parameter int LONG_PRESS_CYCLES = 12_500_000,
    parameter int DOUBLE_GAP_CYCLES = 6_250_000,
    parameter int REPEAT_CYCLES     = 2_500_000
) (
    input  logic clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Short,
    output logic o_Long,
    output logic o_Double,
    output logic o_Repeat,
    output logic o_Held
);
    localparam int MAX_AB = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES : DOUBLE_GAP_CYCLES;
    localparam int MAXP   = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAXP + 1);

    localparam logic [CW-1:0] LONG_N = CW'(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] GAP_N  = CW'(DOUBLE_GAP_CYCLES);
    localparam logic [CW-1:0] REP_N  = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [2:0] {
        ARM, IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          short_nx, long_nx, double_nx, repeat_nx, held_nx;

    // Saturating increment shared by every state.
    assign cnt_inc = (&cnt) ? cnt : cnt + ONE;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            ARM: begin
                cnt_nx = '0;
                if (!i_Switch) state_nx = IDLE;
            end
            IDLE: begin
                if (i_Switch) begin
                    state_nx = PRESSED;
                    cnt_nx   = ONE;
                end else begin
                    cnt_nx = '0;
                end
            end
            PRESSED: begin
                if (i_Switch) begin
                    if (cnt_inc == LONG_N) begin
                        state_nx = LONG_HELD;
                        long_nx  = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = WAIT_SECOND;
                    cnt_nx   = ONE;
                end
            end
            LONG_HELD: begin
                if (i_Switch) begin
                    if (REPEAT_CYCLES != 0 && cnt_inc == REP_N) begin
                        repeat_nx = 1'b1;
                        cnt_nx    = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            WAIT_SECOND: begin
                if (!i_Switch) begin
                    if (cnt_inc == GAP_N) begin
                        state_nx = IDLE;
                        short_nx = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else begin
                    state_nx = SECOND_PRESSED;
                    cnt_nx   = '0;
                end
            end
            SECOND_PRESSED: begin
                if (i_Switch) begin
                    cnt_nx = cnt_inc;
                end else begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                    cnt_nx    = '0;
                end
            end
            default: begin
                state_nx = ARM;
                cnt_nx   = '0;
            end
        endcase
        held_nx = (state_nx == LONG_HELD);
    end

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= ARM;
            cnt      <= '0;
            o_Short  <= 1'b0;
            o_Long   <= 1'b0;
            o_Double <= 1'b0;
            o_Repeat <= 1'b0;
            o_Held   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            o_Short  <= short_nx;
            o_Long   <= long_nx;
            o_Double <= double_nx;
            o_Repeat <= repeat_nx;
            o_Held   <= held_nx;
        end
    end
endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with small timing parameters.
module tb_button_press_classifier;
    logic clk = 1'b0;
    logic i_Rst_n = 1'b0;
    logic i_Switch = 1'b0;
    logic o_Short, o_Long, o_Double, o_Repeat, o_Held;
    int   n_chk = 0;
    int   n_err = 0;

    // Output vector order: {short, long, double, repeat, held}
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] L = 5'b01001;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] R = 5'b00011;
    localparam logic [4:0] H = 5'b00001;

    button_press_classifier #(
        .LONG_PRESS_CYCLES(8),
        .DOUBLE_GAP_CYCLES(5),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk), .i_Rst_n(i_Rst_n), .i_Switch(i_Switch),
        .o_Short(o_Short), .o_Long(o_Long), .o_Double(o_Double),
        .o_Repeat(o_Repeat), .o_Held(o_Held)
    );

    always #5 clk = ~clk;

    wire [4:0] outs = {o_Short, o_Long, o_Double, o_Repeat, o_Held};

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One rising edge with the given sample, then check outputs just after it.
    task automatic edge_chk(input string tag, input logic sw, input logic [4:0] exp);
        i_Switch = sw;
        @(posedge clk);
        #1;
        chk(tag, outs, exp);
    endtask

    task automatic run(input string tag, input logic sw, input int n, input logic [4:0] exp);
        for (int i = 0; i < n; i++) edge_chk(tag, sw, exp);
    endtask

    initial begin
        // Reset with switch released
        #12;
        chk("reset_outs", outs, Z);
        @(negedge clk);
        i_Rst_n = 1'b1;
        edge_chk("arm_to_idle", 1'b0, Z);

        // Short press: high 3, short on 5th low edge
        run("short_hi", 1'b1, 3, Z);
        run("short_lo", 1'b0, 4, Z);
        edge_chk("short_pulse", 1'b0, S);
        run("short_after", 1'b0, 3, Z);

        // Long press with auto-repeat
        run("long_hi1_7", 1'b1, 7, Z);
        edge_chk("long_pulse8", 1'b1, L);
        run("held_9_11", 1'b1, 3, H);
        edge_chk("repeat12", 1'b1, R);
        run("held_13_15", 1'b1, 3, H);
        edge_chk("repeat16", 1'b1, R);
        edge_chk("held17", 1'b1, H);
        edge_chk("long_release", 1'b0, Z);
        run("long_after", 1'b0, 6, Z);

        // Double press, second press held past counter saturation
        run("dbl_hi1", 1'b1, 2, Z);
        run("dbl_gap", 1'b0, 3, Z);
        run("dbl_hi2", 1'b1, 30, Z);
        edge_chk("double_pulse", 1'b0, D);
        run("dbl_after", 1'b0, 6, Z);

        // Gap expires exactly at limit, then new press classifies from PRESSED
        run("gap_hi", 1'b1, 2, Z);
        run("gap_lo", 1'b0, 4, Z);
        edge_chk("gap_short", 1'b0, S);
        run("new_press", 1'b1, 7, Z);
        edge_chk("new_long", 1'b1, L);
        edge_chk("new_release", 1'b0, Z);
        run("idle", 1'b0, 2, Z);

        // Reset mid-LONG_HELD with switch held
        run("rst_hi", 1'b1, 7, Z);
        edge_chk("rst_long", 1'b1, L);
        edge_chk("rst_held", 1'b1, H);
        #2;
        i_Rst_n = 1'b0;
        #1;
        chk("async_reset", outs, Z);
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset", outs, Z);
        i_Rst_n = 1'b1;
        run("post_rst_hi", 1'b1, 12, Z);
        edge_chk("post_rst_lo", 1'b0, Z);
        run("post_rst_re", 1'b1, 7, Z);
        edge_chk("post_rst_long", 1'b1, L);
        edge_chk("post_rst_rel", 1'b0, Z);

        // Switch held through reset and for 20 edges after
        i_Switch = 1'b1;
        @(negedge clk);
        i_Rst_n = 1'b0;
        #1;
        chk("rst2_outs", outs, Z);
        @(negedge clk);
        i_Rst_n = 1'b1;
        run("held_thru_rst", 1'b1, 20, Z);
        edge_chk("arm_release", 1'b0, Z);
        run("arm_hi", 1'b1, 7, Z);
        edge_chk("arm_long", 1'b1, L);
        edge_chk("arm_rel", 1'b0, Z);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 SHALL have parameter LONG_PRESS_CYCLES, default 12_500_000, giving consecutive pressed samples that make a long press; legal range >= 2.
REQ-002 SHALL have parameter DOUBLE_GAP_CYCLES, default 6_250_000, giving the maximum consecutive released samples between the two presses of a double press; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 2_500_000, giving the auto-repeat period while long-held; 0 disables repeat.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 i_Rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_Switch  input  1  debounced switch level, synchronous to clk, 1 = pressed.
REQ-007 o_Short  output  1  one-cycle pulse: single short press classified.
REQ-008 o_Long  output  1  one-cycle pulse: long-press threshold reached.
REQ-009 o_Double  output  1  one-cycle pulse: double press classified.
REQ-010 o_Repeat  output  1  one-cycle pulse every REPEAT_CYCLES while long-held.
REQ-011 o_Held  output  1  level, high while in LONG_HELD.
REQ-012 SHALL have one clock and an asynchronous active-low reset; ports SHALL be named clk and i_Rst_n.

Function
REQ-013 All outputs SHALL be registered; at most one of o_Short, o_Long, o_Double SHALL be high in any cycle.
REQ-014 States SHALL be ARM, IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED; one shared cycle counter, width ceil(log2(max parameter + 1)).
REQ-015 ARM: sample 0 -> IDLE; sample 1 -> stay (a switch held through reset SHALL never register as a press).
REQ-016 IDLE: sample 1 -> PRESSED with counter = 1; sample 0 -> stay.
REQ-017 PRESSED: sample 1 -> counter +1; on the edge where counter would reach LONG_PRESS_CYCLES -> LONG_HELD, o_Long pulse and o_Held asserted on that same edge, counter cleared.
REQ-018 PRESSED: sample 0 before threshold -> WAIT_SECOND with counter = 1.
REQ-019 LONG_HELD: sample 1 -> counter +1; if REPEAT_CYCLES != 0 and counter would reach REPEAT_CYCLES -> o_Repeat pulse, counter cleared; sample 0 -> IDLE, o_Held deasserted on that edge, no o_Short or o_Double.
REQ-020 WAIT_SECOND: sample 0 -> counter +1; on the edge where counter would reach DOUBLE_GAP_CYCLES -> IDLE with o_Short pulse; sample 1 -> SECOND_PRESSED, counter cleared.
REQ-021 SECOND_PRESSED: sample 1 -> stay, regardless of duration (no o_Long); sample 0 -> IDLE with o_Double pulse.
REQ-022 A double press SHALL never also produce o_Short; a long press SHALL never also produce o_Short or o_Double.
REQ-023 Counters SHALL saturate, never wrap, in every state.
REQ-024 Unreachable state encodings SHALL recover to ARM on the next edge.

Reset
REQ-025 i_Rst_n low SHALL immediately force state ARM, counter 0, and all outputs 0, regardless of clk.
REQ-026 Release of reset SHALL be followed by normal operation from ARM on the next rising edge; a reset mid-press SHALL discard that press.

Verification (LONG_PRESS_CYCLES=8, DOUBLE_GAP_CYCLES=5, REPEAT_CYCLES=4)
REQ-027 From IDLE, i_Switch high 3 edges then low -> o_Short pulses on the 5th low-sample edge only; no other pulses.
REQ-028 i_Switch high 17 edges -> o_Long on 8th high edge, o_Held high from that edge; o_Repeat on 12th and 16th edges; first low sample clears o_Held, no further pulses.
REQ-029 High 2, low 3, high 10, low -> o_Double on the first low-sample edge after the second press; no o_Short, no o_Long.
REQ-030 High 2, then low 5 edges, then high 2 -> o_Short on 5th low edge; the later press starts a new classification from PRESSED.
REQ-031 Reset asserted mid-LONG_HELD with i_Switch held high -> outputs 0 immediately; after release, no pulse until i_Switch goes low then high again.
REQ-032 i_Switch held high through and after reset for 20 edges -> no outputs; then low 1 edge, high 8 edges -> o_Long on 8th high edge.
